// File: rtl/trinity_tile_rx.sv
// Tile-side receiver for the Trinity broadcast bus: group filter, mode latch, exec window FSM.
// Optional input deglitch stage enabled by defining TRINITY_TILE_RX_DEGLITCH_EN.
module trinity_tile_rx #(
  parameter logic [1:0] GROUP_ID    = 2'b00,
  parameter int         EXEC_CYCLES = 4,
  parameter int         CNT_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       bus_in,
  output logic [1:0]       active_mode,
  output logic             busy,
  output logic             done,
  output logic             exec_drop,
  output logic             frame_err,
  output logic [CNT_W-1:0] exec_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       frame_q;
  logic             frame_ok;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic             pend_reg, pend_next;
  logic [1:0]       pend_mode_reg, pend_mode_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             drop_reg, drop_next;
  logic             err_reg;
  logic             exec_hist_reg;

`ifdef TRINITY_TILE_RX_DEGLITCH_EN
  logic [7:0] frame_q2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_q  <= 8'h00;
      frame_q2 <= 8'h00;
    end else begin
      frame_q  <= bus_in;
      frame_q2 <= frame_q;
    end
  end

  // A frame only counts once it has been sampled identically twice in a row.
  assign frame_ok = (frame_q == frame_q2);
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_q <= 8'h00;
    end else begin
      frame_q <= bus_in;
    end
  end

  assign frame_ok = 1'b1;
`endif

  logic       f_valid, f_rsv, f_cfg, f_exec;
  logic [1:0] f_group, f_mode;
  logic       is_match, is_err, exec_rise;

  assign f_valid = frame_q[7];
  assign f_rsv   = frame_q[6];
  assign f_group = frame_q[5:4];
  assign f_cfg   = frame_q[3];
  assign f_exec  = frame_q[2];
  assign f_mode  = frame_q[1:0];

  assign is_match  = frame_ok & f_valid & ~f_rsv & (f_group == GROUP_ID) & ~f_cfg;
  assign is_err    = frame_ok & f_valid & f_rsv;
  assign exec_rise = is_match & f_exec & ~exec_hist_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mode_next      = mode_reg;
    pend_next      = pend_reg;
    pend_mode_next = pend_mode_reg;
    count_next     = count_reg;
    drop_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (is_match) begin
          mode_next = f_mode;
          if (exec_rise) begin
            state_next = S_RUN;
            cnt_next   = CNT_LOAD;
          end
        end
      end

      S_RUN, S_DONE: begin
        // While executing, mode changes are deferred; the latest frame wins.
        if (is_match) begin
          if (f_mode != mode_reg) begin
            pend_next      = 1'b1;
            pend_mode_next = f_mode;
          end else begin
            pend_next = 1'b0;
          end
        end
        drop_next = exec_rise;

        if (state_reg == S_RUN) begin
          if (cnt_reg == '0) begin
            state_next = S_DONE;
            count_next = count_reg + CNT_ONE;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end else begin
          state_next = S_IDLE;
        end

        // Deferred mode lands as DONE is entered, or on exit if it arrived during DONE.
        if (pend_next && (state_next != S_RUN)) begin
          mode_next = pend_mode_next;
          pend_next = 1'b0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      mode_reg      <= 2'b00;
      pend_reg      <= 1'b0;
      pend_mode_reg <= 2'b00;
      count_reg     <= '0;
      drop_reg      <= 1'b0;
      err_reg       <= 1'b0;
      exec_hist_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mode_reg      <= mode_next;
      pend_reg      <= pend_next;
      pend_mode_reg <= pend_mode_next;
      count_reg     <= count_next;
      drop_reg      <= drop_next;
      err_reg       <= is_err;
      exec_hist_reg <= is_match & f_exec;
    end
  end

  assign active_mode = mode_reg;
  assign busy        = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign done        = (state_reg == S_DONE);
  assign exec_drop   = drop_reg;
  assign frame_err   = err_reg;
  assign exec_count  = count_reg;

endmodule

// File: tb/tb_trinity_tile_rx.sv
// Directed self-checking bench for trinity_tile_rx; a CNT_W=2 twin shares the bus to exercise wrap.
module tb_trinity_tile_rx;

`ifdef TRINITY_TILE_RX_DEGLITCH_EN
  localparam int HOLD = 2;
  localparam int LAT  = 3;
`else
  localparam int HOLD = 1;
  localparam int LAT  = 2;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] bus_in;

  logic [1:0] active_mode, active_mode_w;
  logic       busy, busy_w, done, done_w;
  logic       exec_drop, exec_drop_w, frame_err, frame_err_w;
  logic [7:0] exec_count;
  logic [1:0] exec_count_w;

  trinity_tile_rx dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bus_in     (bus_in),
    .active_mode(active_mode),
    .busy       (busy),
    .done       (done),
    .exec_drop  (exec_drop),
    .frame_err  (frame_err),
    .exec_count (exec_count)
  );

  trinity_tile_rx #(.CNT_W(2)) dut_w (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bus_in     (bus_in),
    .active_mode(active_mode_w),
    .busy       (busy_w),
    .done       (done_w),
    .exec_drop  (exec_drop_w),
    .frame_err  (frame_err_w),
    .exec_count (exec_count_w)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  int busy_cycles = 0, done_pulses = 0, drops = 0, errs = 0;
  logic [1:0] done_mode = 2'b00;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        done_mode = active_mode;
      end
      if (exec_drop) drops++;
      if (frame_err) errs++;
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
    $display("check %-22s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] f);
    bus_in = f;
    repeat (HOLD) tick();
    bus_in = 8'h00;
    repeat (6) tick();
  endtask

  int b0, d0, x0, e0;
  int exp_cnt = 0;

  initial begin
    // Reset held with an exec frame on the bus
    sys_rst_n = 1'b0;
    bus_in    = 8'h86;
    repeat (3) tick();
    check("rst_active_mode", 32'(active_mode), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_exec_drop",   32'(exec_drop),   32'd0);
    check("rst_frame_err",   32'(frame_err),   32'd0);
    check("rst_exec_count",  32'(exec_count),  32'd0);

    b0 = busy_cycles; d0 = done_pulses;
    sys_rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("rel_busy_early", 32'(busy), 32'd0);
    tick();
    check("rel_busy",        32'(busy),        32'd1);
    check("rel_active_mode", 32'(active_mode), 32'd2);
    bus_in = 8'h00;
    repeat (8) tick();
    exp_cnt++;
    check("rel_busy_cycles", 32'(busy_cycles - b0), 32'd5);
    check("rel_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("rel_exec_count",  32'(exec_count),       32'(exp_cnt));

    // Mode-only frames, including the latency edge
    b0 = busy_cycles;
    bus_in = 8'h81;
    repeat (HOLD) tick();
    bus_in = 8'h00;
    repeat (LAT - HOLD - 1) tick();
    check("mode1_early", 32'(active_mode), 32'd2);
    tick();
    check("mode1_applied", 32'(active_mode), 32'd1);
    send(8'h82);
    check("mode2_applied", 32'(active_mode),      32'd2);
    check("mode_no_busy",  32'(busy_cycles - b0), 32'd0);
    check("mode_count",    32'(exec_count),       32'(exp_cnt));

    // Filtering: other group, cfg frame, reserved-bit error
    e0 = errs;
    send(8'h92);
    check("filt_group", 32'(active_mode), 32'd2);
    send(8'h8A);
    check("filt_cfg", 32'(active_mode), 32'd2);
    send(8'hC1);
    check("err_mode",   32'(active_mode),  32'd2);
    check("err_pulses", 32'(errs - e0),    32'd1);
    check("err_busy",   32'(busy_cycles - b0), 32'd0);

    // Held exec triggers exactly once
    b0 = busy_cycles; d0 = done_pulses; x0 = drops;
    bus_in = 8'h85;
    repeat (12) tick();
    bus_in = 8'h00;
    repeat (4) tick();
    exp_cnt++;
    check("held_busy_cycles", 32'(busy_cycles - b0), 32'd5);
    check("held_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("held_exec_count",  32'(exec_count),       32'(exp_cnt));
    check("held_mode",        32'(active_mode),      32'd1);
    check("held_no_drop",     32'(drops - x0),       32'd0);

    // Exec and mode change arriving during RUN
    d0 = done_pulses; x0 = drops;
    bus_in = 8'h84;
    repeat (HOLD) tick();
    bus_in = 8'h00;
    repeat (HOLD) tick();
    bus_in = 8'h87;
    repeat (HOLD) tick();
    bus_in = 8'h00;
    repeat (LAT - HOLD) tick();
    check("coll_busy_mid", 32'(busy),        32'd1);
    check("coll_mode_mid", 32'(active_mode), 32'd0);
    repeat (8) tick();
    exp_cnt++;
    check("coll_drops",      32'(drops - x0),       32'd1);
    check("coll_done",       32'(done_pulses - d0), 32'd1);
    check("coll_done_mode",  32'(done_mode),        32'd3);
    check("coll_final_mode", 32'(active_mode),      32'd3);
    check("coll_exec_count", 32'(exec_count),       32'(exp_cnt));

    // Five separate execs: the 2-bit twin wraps
    for (int n = 0; n < 5; n++) begin
      send(8'h84);
      repeat (3) tick();
      exp_cnt++;
      check("wrap_count8", 32'(exec_count),   32'(exp_cnt));
      check("wrap_count2", 32'(exec_count_w), 32'(exp_cnt % 4));
    end

`ifdef TRINITY_TILE_RX_DEGLITCH_EN
    // A single-cycle frame is ignored entirely
    b0 = busy_cycles;
    bus_in = 8'h86;
    tick();
    bus_in = 8'h00;
    repeat (6) tick();
    check("glitch_mode", 32'(active_mode),      32'd0);
    check("glitch_busy", 32'(busy_cycles - b0), 32'd0);
`endif

    // Exec start latency
    bus_in = 8'h86;
    repeat (HOLD) tick();
    check("lat_busy_early", 32'(busy), 32'd0);
    bus_in = 8'h00;
    tick();
    check("lat_busy",  32'(busy),        32'd1);
    check("lat_mode",  32'(active_mode), 32'd2);
    repeat (8) tick();
    exp_cnt++;
    check("lat_count", 32'(exec_count), 32'(exp_cnt));

    // Reset mid-RUN aborts without a done pulse
    d0 = done_pulses;
    bus_in = 8'h85;
    repeat (HOLD) tick();
    bus_in = 8'h00;
    repeat (LAT - HOLD + 1) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    sys_rst_n = 1'b0;
    tick();
    check("abort_busy",  32'(busy),        32'd0);
    check("abort_mode",  32'(active_mode), 32'd0);
    check("abort_count", 32'(exec_count),  32'd0);
    sys_rst_n = 1'b1;
    repeat (8) tick();
    check("abort_no_done", 32'(done_pulses - d0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
